// File: rtl/bsg_idiv_iterative_pkg.sv
// rtl/bsg_idiv_iterative_pkg.sv - shared state encoding and helpers for the iterative divider
package bsg_idiv_iterative_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      NEG_A = 3'd1,
      NEG_B = 3'd2,
      CALC  = 3'd3,
      NEG_Q = 3'd4,
      NEG_R = 3'd5,
      DONE  = 3'd6
   } bsg_idiv_state_e;

   // ceil(log2(x)) that never returns zero, so a counter is always at least one bit
   function automatic int safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/bsg_adder_cin.sv
// rtl/bsg_adder_cin.sv - plain adder with carry-in, the divider's only arithmetic unit
module bsg_adder_cin #(
   parameter int width_p = 33
) (
   input  logic [width_p-1:0] a_i,
   input  logic [width_p-1:0] b_i,
   input  logic               cin_i,
   output logic [width_p-1:0] o
);

   assign o = a_i + b_i + {{(width_p-1){1'b0}}, cin_i};

endmodule

// File: rtl/bsg_idiv_iterative_restoring.sv
// rtl/bsg_idiv_iterative_restoring.sv - multi-cycle signed/unsigned restoring integer divider
module bsg_idiv_iterative_restoring
   import bsg_idiv_iterative_pkg::*;
#(
   parameter int width_p = 32
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_and_o,
   input  logic [width_p-1:0] dividend_i,
   input  logic [width_p-1:0] divisor_i,
   input  logic               signed_div_i,
   output logic               v_o,
   output logic [width_p-1:0] quotient_o,
   output logic [width_p-1:0] remainder_o,
   input  logic               yumi_i
);

   localparam int cnt_w_lp = safe_clog2(width_p + 1);

   bsg_idiv_state_e state_q, state_d;

   // quot_q holds the dividend until CALC shifts it out and the quotient in
   logic [width_p-1:0]  quot_q, quot_d;
   logic [width_p-1:0]  div_q, div_d;
   logic [width_p-1:0]  rem_q, rem_d;
   logic [cnt_w_lp-1:0] cnt_q, cnt_d;
   logic                signed_q, signed_d;
   logic                a_sign_q, a_sign_d;
   logic                b_sign_q, b_sign_d;
   logic                zero_q, zero_d;

   logic [width_p:0]    add_a, add_b, add_sum;
   logic                add_cin;
   logic [width_p:0]    shifted;
   logic                a_neg, b_neg;

   bsg_adder_cin #(.width_p(width_p + 1)) adder (
      .a_i   (add_a),
      .b_i   (add_b),
      .cin_i (add_cin),
      .o     (add_sum)
   );

   assign a_neg   = signed_q & a_sign_q;
   assign b_neg   = signed_q & b_sign_q;
   assign shifted = {rem_q, quot_q[width_p-1]};

   // next-state, adder operand steering and datapath updates
   always_comb begin
      state_d  = state_q;
      quot_d   = quot_q;
      div_d    = div_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      signed_d = signed_q;
      a_sign_d = a_sign_q;
      b_sign_d = b_sign_q;
      zero_d   = zero_q;
      add_a    = '0;
      add_b    = '0;
      add_cin  = 1'b0;

      case (state_q)
         IDLE: begin
            if (v_i) begin
               state_d  = NEG_A;
               quot_d   = dividend_i;
               div_d    = divisor_i;
               rem_d    = '0;
               cnt_d    = '0;
               signed_d = signed_div_i;
               a_sign_d = dividend_i[width_p-1];
               b_sign_d = divisor_i[width_p-1];
               zero_d   = (divisor_i == '0);
            end
         end
         NEG_A: begin
            add_b   = ~{1'b0, quot_q};
            add_cin = 1'b1;
            if (a_neg) quot_d = add_sum[width_p-1:0];
            state_d = NEG_B;
         end
         NEG_B: begin
            add_b   = ~{1'b0, div_q};
            add_cin = 1'b1;
            if (b_neg) div_d = add_sum[width_p-1:0];
            cnt_d   = '0;
            state_d = CALC;
         end
         CALC: begin
            // trial subtract; a clear top bit means the partial remainder covered the divisor
            add_a   = shifted;
            add_b   = ~{1'b0, div_q};
            add_cin = 1'b1;
            cnt_d   = cnt_q + cnt_w_lp'(1);
            if (cnt_q == cnt_w_lp'(width_p)) begin
               state_d = NEG_Q;
            end else begin
               rem_d  = add_sum[width_p] ? shifted[width_p-1:0] : add_sum[width_p-1:0];
               quot_d = {quot_q[width_p-2:0], ~add_sum[width_p]};
            end
         end
         NEG_Q: begin
            add_b   = ~{1'b0, quot_q};
            add_cin = 1'b1;
            if ((a_neg ^ b_neg) & ~zero_q) quot_d = add_sum[width_p-1:0];
            state_d = NEG_R;
         end
         NEG_R: begin
            add_b   = ~{1'b0, rem_q};
            add_cin = 1'b1;
            if (a_neg) rem_d = add_sum[width_p-1:0];
            state_d = DONE;
         end
         DONE: begin
            if (yumi_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         quot_q   <= '0;
         div_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         signed_q <= 1'b0;
         a_sign_q <= 1'b0;
         b_sign_q <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         quot_q   <= quot_d;
         div_q    <= div_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         signed_q <= signed_d;
         a_sign_q <= a_sign_d;
         b_sign_q <= b_sign_d;
         zero_q   <= zero_d;
      end
   end

   assign ready_and_o = (state_q == IDLE);
   assign v_o         = (state_q == DONE);
   assign quotient_o  = quot_q;
   assign remainder_o = rem_q;

endmodule
